// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// request/ready instruction-memory port that tolerates wait states.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcplus4,
  output logic        ifid_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, next_state;
  logic        redirect_pending, next_redirect_pending;
  logic [31:0] pend_pc, next_pend_pc;
  logic [31:0] buffer, next_buffer;
  logic [31:0] buf_pc4, next_buf_pc4;
  logic [31:0] next_pc;
  logic [31:0] next_ifid_instr;
  logic [31:0] next_ifid_pcplus4;
  logic        next_ifid_valid;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // pcsrc outranks jump; the jump region comes from the jump's own PC+4 in ID
  assign redirect  = pcsrc | jump;
  assign target    = pcsrc ? branch_target : {ifid_pcplus4[31:28], jump_index, 2'b00};
  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = (state == FETCH) & ~reset;
  assign imem_addr = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      ifid_instr       <= 32'h0;
      ifid_pcplus4     <= 32'h0;
      ifid_valid       <= 1'b0;
      redirect_pending <= 1'b0;
      pend_pc          <= 32'h0;
      buffer           <= 32'h0;
      buf_pc4          <= 32'h0;
    end else begin
      state            <= next_state;
      pc               <= next_pc;
      ifid_instr       <= next_ifid_instr;
      ifid_pcplus4     <= next_ifid_pcplus4;
      ifid_valid       <= next_ifid_valid;
      redirect_pending <= next_redirect_pending;
      pend_pc          <= next_pend_pc;
      buffer           <= next_buffer;
      buf_pc4          <= next_buf_pc4;
    end
  end

  always_comb begin
    next_state            = state;
    next_pc               = pc;
    next_ifid_instr       = ifid_instr;
    next_ifid_pcplus4     = ifid_pcplus4;
    next_ifid_valid       = ifid_valid;
    next_redirect_pending = redirect_pending;
    next_pend_pc          = pend_pc;
    next_buffer           = buffer;
    next_buf_pc4          = buf_pc4;

    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect || redirect_pending) begin
            // The response belongs to the wrong path, so it is dropped.
            next_pc               = redirect ? target : pend_pc;
            next_redirect_pending = 1'b0;
            next_ifid_valid       = 1'b0;
            next_ifid_instr       = 32'h0;
          end else if (stall) begin
            next_buffer  = imem_rdata;
            next_buf_pc4 = pc_plus4;
            next_pc      = pc_plus4;
            next_state   = HOLD;
          end else begin
            next_ifid_instr   = imem_rdata;
            next_ifid_pcplus4 = pc_plus4;
            next_ifid_valid   = 1'b1;
            next_pc           = pc_plus4;
          end
        end else begin
          // The address must stay put until the outstanding response lands.
          if (redirect) begin
            next_redirect_pending = 1'b1;
            next_pend_pc          = target;
            next_ifid_valid       = 1'b0;
            next_ifid_instr       = 32'h0;
          end else if (!stall) begin
            next_ifid_valid = 1'b0;
            next_ifid_instr = 32'h0;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          next_pc         = target;
          next_ifid_valid = 1'b0;
          next_ifid_instr = 32'h0;
          next_state      = FETCH;
        end else if (!stall) begin
          next_ifid_instr   = buffer;
          next_ifid_pcplus4 = buf_pc4;
          next_ifid_valid   = 1'b1;
          next_state        = FETCH;
        end
      end

      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the fetch stage.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural PC, IF/ID contents, and queues holding a
  // parked instruction (stall) and a deferred redirect target (wait state).
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_hold;
  logic [31:0] m_buf[$];
  logic [31:0] m_bufpc4[$];
  logic [31:0] m_pend[$];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pcplus4(ifid_pcplus4), .ifid_valid(ifid_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  // Drive one cycle's inputs mid-cycle; memory answers from the DUT's address.
  task automatic drive(input bit rst, input bit st, input bit ps, input logic [31:0] bt,
                       input bit jp, input logic [25:0] ji, input bit rdy);
    reset = rst; stall = st; pcsrc = ps; branch_target = bt;
    jump = jp; jump_index = ji; imem_ready = rdy;
    #1;
    imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  // Advance the model by the rules of the fetch stage, then clock the DUT.
  task automatic tick();
    logic        redir;
    logic [31:0] tgt;
    redir = pcsrc | jump;
    tgt   = pcsrc ? branch_target : {m_pc4[31:28], jump_index, 2'b00};
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_hold = 1'b0;
      m_buf.delete(); m_bufpc4.delete(); m_pend.delete();
    end else if (!m_hold) begin
      if (imem_ready) begin
        if (redir || m_pend.size() > 0) begin
          m_pc = redir ? tgt : m_pend[0];
          m_pend.delete();
          m_valid = 1'b0; m_instr = 32'h0;
        end else if (stall) begin
          m_buf.push_back(mem_word(m_pc));
          m_bufpc4.push_back(m_pc + 32'd4);
          m_pc = m_pc + 32'd4;
          m_hold = 1'b1;
        end else begin
          m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_pend.delete();
        m_pend.push_back(tgt);
        m_valid = 1'b0; m_instr = 32'h0;
      end else if (!stall) begin
        m_valid = 1'b0; m_instr = 32'h0;
      end
    end else begin
      if (redir) begin
        m_buf.delete(); m_bufpc4.delete();
        m_pc = tgt; m_valid = 1'b0; m_instr = 32'h0; m_hold = 1'b0;
      end else if (!stall) begin
        m_instr = m_buf.pop_front(); m_pc4 = m_bufpc4.pop_front();
        m_valid = 1'b1; m_hold = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 32'h0, 0, 26'h0, 1);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'h0, 0, 26'h0, 1);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
    end
    tick();
    drive(1, 0, 0, 32'h0, 0, 26'h0, 1);
    tick();
    checks++;
    if (pc !== 32'h0 || ifid_instr !== 32'h0 || ifid_pcplus4 !== 32'h0 || ifid_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got pc=%h instr=%h pc4=%h valid=%b expected all zero",
               pc, ifid_instr, ifid_pcplus4, ifid_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * i);
      drive(0, 0, 0, 32'h0, 0, 26'h0, 1);
      checks++;
      if (imem_addr !== a || imem_req !== 1'b1) begin
        errors++; $display("[TB] FAIL seq_addr: got %h req=%b expected %h req=1", imem_addr, imem_req, a);
      end
      tick();
      checks++;
      if (ifid_instr !== (32'hA000_0000 | a) || ifid_pcplus4 !== a + 32'd4 || ifid_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL seq_ifid: got %h/%h/%b expected %h/%h/1",
                 ifid_instr, ifid_pcplus4, ifid_valid, 32'hA000_0000 | a, a + 32'd4);
      end
    end
  endtask

  task automatic test_wait_states();
    bit rdy;
    for (int i = 0; i < 9; i++) begin
      rdy = (i % 3 == 2);
      drive(0, 0, 0, 32'h0, 0, 26'h0, rdy);
      checks++;
      if (imem_addr !== m_pc) begin
        errors++; $display("[TB] FAIL wait_addr: got %h expected %h", imem_addr, m_pc);
      end
      tick();
      checks++;
      if (ifid_valid !== rdy || ifid_instr !== m_instr || ifid_pcplus4 !== m_pc4) begin
        errors++;
        $display("[TB] FAIL wait_ifid: got %b/%h/%h expected %b/%h/%h",
                 ifid_valid, ifid_instr, ifid_pcplus4, rdy, m_instr, m_pc4);
      end
    end
  endtask

  task automatic test_stall_on_response();
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    drive(0, 1, 0, 32'h0, 0, 26'h0, 1);
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++; $display("[TB] FAIL stall_addr: got %h expected 00000008", imem_addr);
    end
    tick();
    checks++;
    if (ifid_instr !== 32'hA000_0004 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_hold1: got %h/%b expected a0000004/1", ifid_instr, ifid_valid);
    end
    drive(0, 1, 0, 32'h0, 0, 26'h0, 1);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_req_hold: got %b expected 0", imem_req);
    end
    tick();
    checks++;
    if (ifid_instr !== 32'hA000_0004) begin
      errors++; $display("[TB] FAIL stall_hold2: got %h expected a0000004", ifid_instr);
    end
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1);
    tick();
    checks++;
    if (ifid_instr !== 32'hA000_0008 || ifid_pcplus4 !== 32'hC || ifid_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: got %h/%h/%b expected a0000008/0000000c/1",
               ifid_instr, ifid_pcplus4, ifid_valid);
    end
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1);
    checks++;
    if (imem_addr !== 32'hC || imem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_next_addr: got %h req=%b expected 0000000c req=1", imem_addr, imem_req);
    end
    tick();
  endtask

  task automatic test_redirect_during_wait();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, (i == 0), 32'h100, 0, 26'h0, (i == 2));
      checks++;
      if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
        errors++; $display("[TB] FAIL redir_wait_addr: got %h req=%b expected 00000020 req=1", imem_addr, imem_req);
      end
      tick();
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
        errors++; $display("[TB] FAIL redir_flush: got %b/%h expected 0/00000000", ifid_valid, ifid_instr);
      end
    end
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1);
    checks++;
    if (imem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL redir_target: got %h expected 00000100", imem_addr);
    end
    tick();
    checks++;
    if (ifid_instr !== 32'hA000_0100 || ifid_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL redir_deliver: got %h/%b expected a0000100/1", ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_jump_priority();
    do_reset();
    drive(0, 0, 1, 32'h4000_000C, 0, 26'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    checks++;
    if (ifid_pcplus4 !== 32'h4000_0010) begin
      errors++; $display("[TB] FAIL jump_setup: got %h expected 40000010", ifid_pcplus4);
    end
    drive(0, 0, 0, 32'h0, 1, 26'h40, 1); tick();
    checks++;
    if (imem_addr !== 32'h4000_0100 || ifid_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL jump_target: got %h/%b expected 40000100/0", imem_addr, ifid_valid);
    end
    drive(0, 0, 1, 32'h4000_000C, 0, 26'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    drive(0, 0, 1, 32'h200, 1, 26'h40, 1); tick();
    checks++;
    if (imem_addr !== 32'h200) begin
      errors++; $display("[TB] FAIL branch_priority: got %h expected 00000200", imem_addr);
    end
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0, 1); tick();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    checks++;
    if (pc !== 32'h0 || ifid_pcplus4 !== 32'h0 || ifid_instr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL pc_wrap: got pc=%h pc4=%h instr=%h expected 0/0/fffffffc",
                         pc, ifid_pcplus4, ifid_instr);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    drive(0, 1, 0, 32'h0, 0, 26'h0, 1); tick();
    drive(1, 1, 0, 32'h0, 0, 26'h0, 1); tick();
    checks++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      errors++; $display("[TB] FAIL hold_reset: got pc=%h valid=%b instr=%h expected 0/0/0",
                         pc, ifid_valid, ifid_instr);
    end
    drive(0, 0, 0, 32'h0, 0, 26'h0, 1); tick();
    checks++;
    if (ifid_instr !== 32'hA000_0000 || ifid_pcplus4 !== 32'h4) begin
      errors++; $display("[TB] FAIL hold_buffer_dropped: got %h/%h expected a0000000/00000004",
                         ifid_instr, ifid_pcplus4);
    end
  endtask

  task automatic test_random();
    bit          rst, st, ps, jp, rdy;
    logic [31:0] bt;
    logic [25:0] ji;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      jp  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      bt  = {$urandom_range(0, 32'h3FFF), 2'b00};
      ji  = 26'($urandom_range(0, 32'h3FFF));
      drive(rst, st, ps, bt, jp, ji, rdy);
      checks++;
      if (imem_req !== (!rst && !m_hold) || imem_addr !== m_pc) begin
        errors++; $display("[TB] FAIL rand_port: got req=%b addr=%h expected req=%b addr=%h",
                           imem_req, imem_addr, (!rst && !m_hold), m_pc);
      end
      tick();
      checks++;
      if (pc !== m_pc || ifid_instr !== m_instr || ifid_pcplus4 !== m_pc4 || ifid_valid !== m_valid) begin
        errors++;
        $display("[TB] FAIL rand_state: got pc=%h instr=%h pc4=%h valid=%b expected %h/%h/%h/%b",
                 pc, ifid_instr, ifid_pcplus4, ifid_valid, m_pc, m_instr, m_pc4, m_valid);
      end
    end
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_hold = 1'b0;
    reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_index = 26'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    @(posedge clock);
    #1;
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_on_response();
    test_redirect_during_wait();
    test_jump_priority();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register, drives a request/ready instruction-memory port that may insert wait states, and applies the decode-stage controls. It consumes PCSrc and the branch target from the branch logic, Jump and the jump index from main control, and the load-use stall (bubble_idex). Its IF/ID outputs feed ID-stage decode, main control and the stall detector.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- stall  in  1  load-use stall (bubble_idex); hold IF/ID contents
- pcsrc  in  1  taken branch; redirect to branch_target
- branch_target  in  32  branch destination
- jump  in  1  jump decoded in ID; redirect to jump target
- jump_index  in  26  instr[25:0] of the jump in ID
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to pc
- imem_ready  in  1  response valid; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- pc  out  32  current fetch PC
- ifid_instr  out  32  instruction to ID
- ifid_pcplus4  out  32  PC+4 of ifid_instr
- ifid_valid  out  1  ifid_instr is a real instruction

## Operation
- Reset values: pc=RESET_PC, ifid_instr=0, ifid_pcplus4=0, ifid_valid=0, state=FETCH, redirect_pending=0, buffer=0. imem_req=0 while reset is high.
- Redirect: redirect = pcsrc | jump. Target is branch_target if pcsrc=1, else {ifid_pcplus4[31:28], jump_index, 2'b00}. pcsrc has priority over jump.
- Flush: on any cycle with redirect=1, next ifid_valid=0 and ifid_instr=0. Redirect takes priority over stall.
- Every cycle that loads ifid_valid=0 also loads ifid_instr=0. Opcode 0 decodes as a harmless write to $0.
- imem_req = (state==FETCH) & ~reset. imem_addr = pc at all times.
- While imem_req=1 and imem_ready=0, pc and imem_addr are held stable.
- FETCH, imem_ready=1:
  - If redirect or redirect_pending: discard imem_rdata. pc <= current-cycle target if redirect=1, else pend_pc. Clear redirect_pending. Flush IF/ID. Stay in FETCH.
  - Else if stall: buffer <= imem_rdata, buf_pc4 <= pc+4, pc <= pc+4. IF/ID holds. Go to HOLD.
  - Else: ifid_instr <= imem_rdata, ifid_pcplus4 <= pc+4, ifid_valid <= 1, pc <= pc+4.
- FETCH, imem_ready=0:
  - If redirect: redirect_pending <= 1, pend_pc <= target. A later redirect before ready overwrites pend_pc. Flush IF/ID.
  - Else if stall: IF/ID holds.
  - Else: ifid_valid <= 0 (bubble into ID).
- HOLD (imem_req=0):
  - If redirect: drop buffer, pc <= target, flush IF/ID, go to FETCH.
  - Else if !stall: IF/ID <= {buffer, buf_pc4, valid=1}, go to FETCH.
  - Else: stay in HOLD.
- PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0. No alignment check.

## Timing
- Zero-wait memory (imem_ready tied 1): one instruction per cycle. Data accepted at edge n appears on IF/ID after edge n. Branch penalty is set by the stage that drives pcsrc.
- Every wait cycle with no stall inserts exactly one ifid_valid=0 bubble.
- Stall coinciding with a response costs one extra cycle after stall drops (HOLD→FETCH). No instruction is lost or duplicated.
- Redirect while a response is outstanding: the fetch address switches only after the outstanding response (ready) is consumed. No new request is issued mid-wait.
- Reset mid-operation: the next edge restores all reset values. Any buffered or pending fetch is discarded.

## Test plan
- Reset sequence: RESET_PC=0, ready=1, rdata=addr|0xA000_0000. Release reset -> imem_addr 0,4,8,… on successive cycles. ifid_instr 0xA000_0000, 0xA000_0004… one cycle later, with ifid_pcplus4 4,8,….
- Wait states: ready high every 3rd cycle -> ifid_valid pattern 1,0,0 repeating. ifid_instr=0 in gap cycles. Addresses increase by 4 per accepted fetch.
- Stall on response: stall=1 for 2 cycles starting the cycle ready returns for addr 8 -> IF/ID keeps the addr-4 instruction for 2 cycles. The addr-8 instruction appears the cycle after stall drops. Next imem_addr is 12, req low during HOLD.
- Redirect during wait: fetching 0x20 with ready low, pulse pcsrc=1 with target 0x100; ready rises 2 cycles later -> 0x20 data discarded. ifid_valid=0 throughout. Next imem_addr=0x100.
- Jump and priority: ifid_pcplus4=0x4000_0010, jump_index=0x40, jump=1 -> next imem_addr=0x4000_0100. Same cycle with pcsrc=1, branch_target=0x200 -> next imem_addr=0x200.
- Reset in HOLD: enter HOLD with stall high, assert reset one cycle -> pc=RESET_PC, ifid_valid=0, ifid_instr=0. Buffered instruction never delivered.
